// File: rtl/column_byte_serializer.sv
// rtl/column_byte_serializer.sv - two-entry column buffer draining one byte per cycle with row/column tags
module column_byte_serializer #(
   parameter int COLS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [7:0] in4,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out,
   output logic [1:0] out_row,
   output logic [1:0] out_col,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       block_done
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   localparam logic [1:0] LAST_COL = 2'(COLS - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] a [4];
   logic [7:0] p [4];
   logic [1:0] row;
   logic [1:0] col;
   logic       done;
   logic       accept;
   logic       transfer;
   logic       col_end;
   logic       load_a_in;
   logic       load_a_p;
   logic       load_p;

   assign in_ready   = (state != TWO);
   assign out_valid  = (state != EMPTY);
   assign out        = a[row];
   assign out_row    = row;
   assign out_col    = col;
   assign out_last   = out_valid && (row == 2'd3) && (col == LAST_COL);
   assign block_done = done;

   assign accept   = in_valid && in_ready;
   assign transfer = out_valid && out_ready;
   assign col_end  = transfer && (row == 2'd3);

   // Next state and which entry gets loaded from where this cycle
   always_comb begin
      state_nxt = state;
      load_a_in = 1'b0;
      load_a_p  = 1'b0;
      load_p    = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_a_in = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (col_end) begin
               if (accept) begin
                  load_a_in = 1'b1;
               end else begin
                  state_nxt = EMPTY;
               end
            end else if (accept) begin
               load_p    = 1'b1;
               state_nxt = TWO;
            end
         end
         TWO: begin
            if (col_end) begin
               load_a_p  = 1'b1;
               state_nxt = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Entry storage, row/column counters and the block_done pulse; clear wins over any handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
         for (int i = 0; i < 4; i++) begin
            a[i] <= 8'd0;
            p[i] <= 8'd0;
         end
         row  <= 2'd0;
         col  <= 2'd0;
         done <= 1'b0;
      end else if (clear) begin
         state <= EMPTY;
         row   <= 2'd0;
         col   <= 2'd0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_a_in) begin
            a[0] <= in1;
            a[1] <= in2;
            a[2] <= in3;
            a[3] <= in4;
         end else if (load_a_p) begin
            for (int i = 0; i < 4; i++) begin
               a[i] <= p[i];
            end
         end
         if (load_p) begin
            p[0] <= in1;
            p[1] <= in2;
            p[2] <= in3;
            p[3] <= in4;
         end
         if (transfer) begin
            row <= row + 2'd1;
         end
         if (col_end) begin
            col <= (col == LAST_COL) ? 2'd0 : col + 2'd1;
         end
         done <= transfer && out_last;
      end
   end

endmodule

// File: tb/tb_column_byte_serializer.sv
// tb/tb_column_byte_serializer.sv - table, directed and random checks against a byte-queue reference model
module tb_column_byte_serializer;

   localparam int COLS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] in1 = 8'd0, in2 = 8'd0, in3 = 8'd0, in4 = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out;
   logic [1:0] out_row;
   logic [1:0] out_col;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic       block_done;

   column_byte_serializer #(.COLS(COLS)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .out_row(out_row), .out_col(out_col),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .block_done(block_done)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // reference model: bytes still owed to the consumer, plus total bytes delivered since flush
   logic [7:0] mq [$];
   int         bcnt  = 0;
   bit         mdone = 1'b0;

   // what the DUT did in the most recent stepped cycle
   bit         dut_tr;
   bit         dut_acc;
   logic [7:0] dut_byte;

   typedef struct {
      logic        iv;
      logic [31:0] bytes;
      logic        ordy;
      logic        ev;
      logic        er;
      logic [7:0]  eo;
      logic [1:0]  erow;
      logic [1:0]  ecol;
      logic        elast;
      logic        edone;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int m_cols();
      return (mq.size() + 3) / 4;
   endfunction

   task automatic model_reset();
      mq.delete();
      bcnt  = 0;
      mdone = 1'b0;
   endtask

   task automatic model_update();
      bit v, acc, tr, last;
      if (clear) begin
         model_reset();
         return;
      end
      v    = mq.size() > 0;
      acc  = in_valid && (m_cols() < 2);
      tr   = v && out_ready;
      last = v && (bcnt % 4 == 3) && ((bcnt / 4) % COLS == COLS - 1);
      mdone = tr && last;
      if (tr) begin
         void'(mq.pop_front());
         bcnt++;
      end
      if (acc) begin
         mq.push_back(in1);
         mq.push_back(in2);
         mq.push_back(in3);
         mq.push_back(in4);
      end
   endtask

   task automatic model_check();
      bit v;
      v = mq.size() > 0;
      chk("out_valid", int'(out_valid), int'(v));
      chk("in_ready", int'(in_ready), int'(m_cols() < 2));
      chk("out_row", int'(out_row), bcnt % 4);
      chk("out_col", int'(out_col), (bcnt / 4) % COLS);
      chk("out_last", int'(out_last), int'(v && (bcnt % 4 == 3) && ((bcnt / 4) % COLS == COLS - 1)));
      chk("block_done", int'(block_done), int'(mdone));
      if (v) chk("out", int'(out), int'(mq[0]));
   endtask

   // called just after a falling edge with inputs already driven
   task automatic step(input bit use_model);
      #1;
      if (use_model) model_check();
      dut_tr   = out_valid && out_ready;
      dut_acc  = in_valid && in_ready;
      dut_byte = out;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drive(input bit iv, input logic [31:0] b, input bit ordy);
      in_valid  = iv;
      {in4, in3, in2, in1} = b;
      out_ready = ordy;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear = 1'b0;
      drive(1'b0, 32'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   vec_t       tbl [6];
   logic [7:0] got [$];
   int         n;
   int         k;
   bit         ok;

   initial begin
      tbl[0] = '{1'b1, 32'hE0_31_88_32, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'h0,           1'b1, 1'b1, 1'b1, 8'h32, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 32'h0,           1'b1, 1'b1, 1'b1, 8'h88, 2'd1, 2'd0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 32'h0,           1'b1, 1'b1, 1'b1, 8'h31, 2'd2, 2'd0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 32'h0,           1'b1, 1'b1, 1'b1, 8'hE0, 2'd3, 2'd0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 32'h0,           1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 2'd1, 1'b0, 1'b0};

      // reset values while rst is held
      #2;
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst in_ready", int'(in_ready), 1);
      chk("rst out", int'(out), 0);
      chk("rst block_done", int'(block_done), 0);
      do_reset();

      // single column from the table
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].iv, tbl[i].bytes, tbl[i].ordy);
         #1;
         chk("tbl out_valid", int'(out_valid), int'(tbl[i].ev));
         chk("tbl in_ready", int'(in_ready), int'(tbl[i].er));
         if (tbl[i].ev) chk("tbl out", int'(out), int'(tbl[i].eo));
         chk("tbl out_row", int'(out_row), int'(tbl[i].erow));
         chk("tbl out_col", int'(out_col), int'(tbl[i].ecol));
         chk("tbl out_last", int'(out_last), int'(tbl[i].elast));
         chk("tbl block_done", int'(block_done), int'(tbl[i].edone));
         @(posedge clk);
         model_update();
         @(negedge clk);
      end

      // full block streaming with bytes 0x00..0x0F
      do_reset();
      got.delete();
      k = 0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         drive(k < 4, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 1'b1);
         step(1'b1);
         if (dut_acc) k++;
         if (dut_tr) got.push_back(dut_byte);
         if (c >= 1 && c <= 16 && dut_tr) n++;
      end
      chk("stream gapless", n, 16);
      ok = (got.size() == 16);
      for (int i = 0; i < got.size() && i < 16; i++) if (got[i] != 8'(i)) ok = 1'b0;
      chk("stream bytes", int'(ok), 1);

      // backpressure: three offers with consumer stalled
      do_reset();
      n = 0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, {8'(c), 8'(c), 8'(c), 8'(16*c + 5)}, 1'b0);
         step(1'b1);
         if (dut_acc) n++;
      end
      chk("bp accepted", n, 2);
      k = -1;
      for (int c = 0; c < 10 && k < 0; c++) begin
         drive(1'b1, 32'h02_02_02_25, 1'b1);
         step(1'b1);
         if (dut_acc) k = c;
      end
      chk("bp third accept cycle", k, 4);
      drive(1'b0, 32'd0, 1'b1);
      for (int c = 0; c < 10; c++) step(1'b1);

      // stall mid-column
      do_reset();
      drive(1'b1, 32'hA3_A2_A1_A0, 1'b0);
      step(1'b1);
      got.delete();
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 32'd0, (c == 1 || c == 2) ? 1'b0 : 1'b1);
         step(1'b1);
         if (dut_tr) got.push_back(dut_byte);
      end
      ok = (got.size() == 4);
      for (int i = 0; i < got.size() && i < 4; i++) if (got[i] != 8'(8'hA0 + i)) ok = 1'b0;
      chk("stall bytes once in order", int'(ok), 1);

      // clear with two columns buffered and row 2 showing
      do_reset();
      drive(1'b1, 32'h13_12_11_10, 1'b0);
      step(1'b1);
      drive(1'b1, 32'h23_22_21_20, 1'b1);
      step(1'b1);
      drive(1'b0, 32'd0, 1'b1);
      step(1'b1);
      chk("pre-clear row", int'(out_row), 2);
      clear = 1'b1;
      drive(1'b1, 32'h33_32_31_30, 1'b1);
      step(1'b1);
      clear = 1'b0;
      #1;
      chk("clear out_valid", int'(out_valid), 0);
      chk("clear in_ready", int'(in_ready), 1);
      chk("clear out_col", int'(out_col), 0);
      drive(1'b1, 32'h43_42_41_40, 1'b1);
      step(1'b1);
      drive(1'b0, 32'd0, 1'b1);
      #1;
      chk("post-clear out", int'(out), 8'h40);
      chk("post-clear row/col", int'({out_row, out_col}), 0);
      step(1'b1);
      for (int c = 0; c < 4; c++) step(1'b1);

      // async reset at column 2 row 1
      do_reset();
      k = 0;
      for (int c = 0; c < 40 && !(bcnt == 9); c++) begin
         drive(1'b1, {8'(k), 8'(k), 8'(k), 8'(k + 1)}, 1'b1);
         step(1'b1);
         if (dut_acc) k++;
      end
      chk("pre-reset position", int'({out_col, out_row}), 4'b1001);
      #2;
      rst = 1'b0;
      #1;
      chk("arst out_valid", int'(out_valid), 0);
      chk("arst out", int'(out), 0);
      chk("arst row/col", int'({out_row, out_col}), 0);
      chk("arst in_ready", int'(in_ready), 1);
      chk("arst last/done", int'({out_last, block_done}), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 32'h03_02_01_00, 1'b1);
      for (int c = 0; c < 6; c++) step(1'b1);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
         clear = ($urandom % 50) == 0;
         step(1'b1);
      end
      clear = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
